// File: rtl/unified_mem_arbiter_if.sv
// Bundle of both requester handshakes plus the shared memory bus of the
// unified instruction/data memory arbiter.
interface unified_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req0;
  logic              we0;
  logic [ADDR_W-1:0] addr0;
  logic [DATA_W-1:0] wdata0;
  logic              ack0;
  logic              err0;
  logic [DATA_W-1:0] rdata0;

  logic              req1;
  logic              we1;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata1;
  logic              ack1;
  logic              err1;
  logic [DATA_W-1:0] rdata1;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic              busy;
  logic              owner;

  modport slave (
    input  req0, we0, addr0, wdata0,
    input  req1, we1, addr1, wdata1,
    input  mem_rdata,
    output ack0, err0, rdata0,
    output ack1, err1, rdata1,
    output mem_en, mem_we, mem_addr, mem_wdata,
    output busy, owner
  );

  modport master (
    output req0, we0, addr0, wdata0,
    output req1, we1, addr1, wdata1,
    output mem_rdata,
    input  ack0, err0, rdata0,
    input  ack1, err1, rdata1,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    input  busy, owner
  );
endinterface

// File: rtl/unified_mem_arbiter.sv
// Round-robin arbiter sharing one fixed-latency memory between the CPU (port 0)
// and the loader/debug DMA (port 1); misaligned word accesses complete with err.
module unified_mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LAT    = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  unified_mem_arbiter_if.slave    bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(LAT - 1);

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              owner_q, owner_d;
  logic              we_q, we_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;

  logic              grant_port;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  // Winner selection: a lone requester wins, contention goes to the port that
  // was not granted last.
  always_comb begin
    if (bus.req0 && bus.req1) begin
      grant_port = ~owner_q;
    end else begin
      grant_port = bus.req1;
    end
    sel_we    = grant_port ? bus.we1    : bus.we0;
    sel_addr  = grant_port ? bus.addr1  : bus.addr0;
    sel_wdata = grant_port ? bus.wdata1 : bus.wdata0;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    owner_d     = owner_q;
    we_d        = we_q;
    err_d       = err_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rdata0_d    = rdata0_q;
    rdata1_d    = rdata1_q;

    case (state_q)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          owner_d     = grant_port;
          we_d        = sel_we;
          mem_addr_d  = sel_addr;
          mem_wdata_d = sel_wdata;
          cnt_d       = CNT_INIT;
          if (sel_addr[1:0] != 2'b00) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            err_d   = 1'b0;
            state_d = ACCESS;
          end
        end
      end
      ACCESS: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd0) begin
          // The memory presents read data in the last access cycle only.
          if (!we_q) begin
            if (owner_q) begin
              rdata1_d = bus.mem_rdata;
            end else begin
              rdata0_d = bus.mem_rdata;
            end
          end
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      owner_q     <= 1'b1;
      we_q        <= 1'b0;
      err_q       <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      owner_q     <= owner_d;
      we_q        <= we_d;
      err_q       <= err_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rdata0_q    <= rdata0_d;
      rdata1_q    <= rdata1_d;
    end
  end

  // Strobes decode straight from the state flops, so a reset kills them at once.
  assign bus.mem_en    = (state_q == ACCESS);
  assign bus.mem_we    = (state_q == ACCESS) && we_q && (cnt_q == CNT_INIT);
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;

  assign bus.ack0   = (state_q == DONE) && !owner_q;
  assign bus.ack1   = (state_q == DONE) && owner_q;
  assign bus.err0   = (state_q == DONE) && !owner_q && err_q;
  assign bus.err1   = (state_q == DONE) && owner_q && err_q;
  assign bus.rdata0 = rdata0_q;
  assign bus.rdata1 = rdata1_q;

  assign bus.busy  = (state_q != IDLE);
  assign bus.owner = owner_q;

endmodule
